// File: rtl/sqrt_iter_ctrl_if.sv
// System-side handshake of the iterative square-root unit: request/operand in,
// busy/done status and result out.
interface sqrt_iter_ctrl_if #(
  parameter int DATA_W = 30
);
  localparam int ROOT_W = DATA_W / 2;

  logic              start_i;
  logic [DATA_W-1:0] radicand_i;
  logic              busy_o;
  logic              done_o;
  logic [ROOT_W-1:0] root_o;
  logic [ROOT_W:0]   rem_o;

  modport master (
    output start_i, radicand_i,
    input  busy_o, done_o, root_o, rem_o
  );

  modport slave (
    input  start_i, radicand_i,
    output busy_o, done_o, root_o, rem_o
  );
endinterface

// File: rtl/sqrt_iter_ctrl.sv
// Restoring digit-by-digit integer square root, one root bit per cycle; the
// trial subtraction decision comes from the external 17-bit less-than Comparator.
module sqrt_iter_ctrl #(
  parameter  int DATA_W = 30,
  localparam int ROOT_W = DATA_W / 2,
  localparam int CMP_W  = DATA_W / 2 + 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  sqrt_iter_ctrl_if.slave  bus,
  input  logic             cmp_lt_i,
  output logic [CMP_W-1:0] cmp_a_o,
  output logic [CMP_W-1:0] cmp_b_o
);

  localparam int CNT_W = $clog2(ROOT_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rad;
  logic [ROOT_W:0]   rem;
  logic [ROOT_W-1:0] root;
  logic [ROOT_W-1:0] root_q;
  logic [ROOT_W:0]   rem_q;

  logic [CMP_W-1:0]  rem_sh;
  logic [CMP_W-1:0]  trial;
  logic [ROOT_W:0]   rem_nxt;
  logic [ROOT_W-1:0] root_nxt;
  logic              busy;
  logic              done;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_i) state_nxt = CALC;
      CALC:    if (cnt == '0)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC:    busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // The remainder stays below 2^15 until the final step, so dropping its top
  // bit when shifting in the next radicand pair never loses information.
  always_comb begin
    rem_sh = CMP_W'({rem, rad[{cnt, 1'b0} +: 2]});
    trial  = CMP_W'({root, 2'b01});
    if (cmp_lt_i) begin
      rem_nxt  = rem_sh[ROOT_W:0];
      root_nxt = {root[ROOT_W-2:0], 1'b0};
    end else begin
      rem_nxt  = (ROOT_W+1)'(rem_sh - trial);
      root_nxt = {root[ROOT_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rad    <= '0;
      rem    <= '0;
      root   <= '0;
      cnt    <= '0;
      root_q <= '0;
      rem_q  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start_i) begin
          rad  <= bus.radicand_i;
          rem  <= '0;
          root <= '0;
          cnt  <= CNT_W'(ROOT_W - 1);
        end
        CALC: begin
          rem  <= rem_nxt;
          root <= root_nxt;
          if (cnt == '0) begin
            root_q <= root_nxt;
            rem_q  <= rem_nxt;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmp_a_o    = rem_sh;
  assign cmp_b_o    = trial;
  assign bus.busy_o = busy;
  assign bus.done_o = done;
  assign bus.root_o = root_q;
  assign bus.rem_o  = rem_q;

endmodule
